// File: rtl/led_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen_if
// Desc     : Control and LED bundle between the pattern generator and the
//            logic that drives it (switches / control register side).
// Revision : 1.0 - initial release
// ============================================================================
interface led_pattern_gen_if #(
  parameter int LED_NUM = 4
);
  logic               en;
  logic [1:0]         mode;
  logic [LED_NUM-1:0] led;
  logic               tick;

  // Controller side: drives enable/mode, observes the LEDs
  modport master (output en, output mode, input led, input tick);
  // Generator side
  modport slave  (input en, input mode, output led, output tick);
endinterface
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen
// Desc     : Multi-channel LED pattern generator. A free-running prescaler
//            emits a step every CNT_MAX+1 clocks; each step advances one of
//            four patterns (toggle, running light, ping-pong, binary count).
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
  parameter int               LED_NUM = 4,
  parameter int               CNT_W   = 25,
  parameter logic [CNT_W-1:0] CNT_MAX = 25'd24_999_999
) (
  input  logic             clk,
  input  logic             rst_n,
  led_pattern_gen_if.slave pat_if
);

  localparam logic [1:0] MODE_TOGGLE = 2'd0;
  localparam logic [1:0] MODE_RUN    = 2'd1;
  localparam logic [1:0] MODE_PP     = 2'd2;
  localparam logic [1:0] MODE_CNT    = 2'd3;

  typedef enum logic [0:0] {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [1:0]         mode_q,  mode_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [LED_NUM-1:0] led_q,   led_d;
  dir_t               dir_q,   dir_d;
  logic               tick_q,  tick_d;

  logic               mode_chg;
  logic [LED_NUM-1:0] init_pat;
  logic [LED_NUM-1:0] rot_led;
  logic [LED_NUM-1:0] pp_led;
  dir_t               pp_dir;
  logic [LED_NUM-1:0] step_led;
  dir_t               step_dir;

  assign mode_chg = (pat_if.mode != mode_q);

  // Starting pattern of the mode being switched into
  always_comb begin
    init_pat = '1;
    case (pat_if.mode)
      MODE_TOGGLE: init_pat = '1;
      MODE_RUN:    init_pat = LED_NUM'(1);
      MODE_PP:     init_pat = LED_NUM'(1);
      default:     init_pat = '0;
    endcase
  end

  // A single LED has nowhere to move: running light and ping-pong hold it
  generate
    if (LED_NUM == 1) begin : g_single
      assign rot_led = led_q;
      assign pp_led  = led_q;
      assign pp_dir  = dir_q;
    end else begin : g_multi
      assign rot_led = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};

      // Ping-pong bounces off either end, flipping direction on the end bit
      always_comb begin
        pp_led = led_q;
        pp_dir = dir_q;
        if (dir_q == DIR_UP) begin
          if (led_q[LED_NUM-1]) begin
            pp_dir = DIR_DOWN;
            pp_led = led_q >> 1;
          end else begin
            pp_led = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            pp_dir = DIR_UP;
            pp_led = led_q << 1;
          end else begin
            pp_led = led_q >> 1;
          end
        end
      end
    end
  endgenerate

  // Value the LEDs take on a step, selected by the registered mode
  always_comb begin
    step_led = led_q;
    step_dir = dir_q;
    case (mode_q)
      MODE_TOGGLE: step_led = ~led_q;
      MODE_RUN:    step_led = rot_led;
      MODE_PP: begin
        step_led = pp_led;
        step_dir = pp_dir;
      end
      default:     step_led = led_q + LED_NUM'(1);
    endcase
  end

  // Next state: a mode change restarts everything and outranks a step
  always_comb begin
    mode_d  = mode_q;
    count_d = count_q;
    led_d   = led_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    if (mode_chg) begin
      mode_d  = pat_if.mode;
      count_d = '0;
      dir_d   = DIR_UP;
      led_d   = init_pat;
    end else if (pat_if.en) begin
      if (count_q == CNT_MAX) begin
        count_d = '0;
        led_d   = step_led;
        dir_d   = step_dir;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset loads the toggle mode's all-on pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_TOGGLE;
      count_q <= '0;
      led_q   <= '1;
      dir_q   <= DIR_UP;
      tick_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      count_q <= count_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
    end
  end

  assign pat_if.led  = led_q;
  assign pat_if.tick = tick_q;

endmodule
`default_nettype wire
